// File: rtl/mem_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stall_ctrl
//  Brief    : Sequences the EX/MEM register and surrounding pipeline stages
//             around multi-cycle data-memory accesses. It drives a req/ack
//             handshake, inserts load-use bubbles, counts stall cycles
//             (saturating), and raises a sticky timeout error.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stall_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             EXMEM_MemRead_i,
    input  logic             EXMEM_MemWrite_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RDaddr_i,
    input  logic [4:0]       IFID_RS1addr_i,
    input  logic [4:0]       IFID_RS2addr_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             PC_stall_o,
    output logic             IFID_stall_o,
    output logic             IDEX_stall_o,
    output logic             IDEX_bubble_o,
    output logic             EXMEM_stall_o,
    output logic             MEMWB_bubble_o,
    output logic             busy_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // The wait counter only has to reach TIMEOUT-1; keep at least one bit so
    // the declaration stays legal when the timeout is disabled.
    localparam int                c_WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_we;
    logic                  w_we_nxt;
    logic [c_WAIT_W-1:0]   r_wait_cnt;
    logic [c_WAIT_W-1:0]   w_wait_nxt;
    logic [CNT_W-1:0]      r_stall_cnt;

    logic                  w_memop;
    logic                  w_lu_hazard;
    logic                  w_mem_stall;

    assign w_memop     = EXMEM_MemRead_i | EXMEM_MemWrite_i;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign w_lu_hazard = IDEX_MemRead_i & (IDEX_RDaddr_i != 5'd0) &
                         ((IDEX_RDaddr_i == IFID_RS1addr_i) |
                          (IDEX_RDaddr_i == IFID_RS2addr_i));

    // The memory stall starts in the very cycle the memop is seen in IDLE, so
    // EX/MEM is frozen before the request goes out; ERROR holds it forever.
    assign w_mem_stall = ((r_state == ST_IDLE) & w_memop) |
                         (r_state == ST_ACCESS) |
                         (r_state == ST_ERROR);

    // State, latched write flag, wait counter and stall counter.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_we       <= w_we_nxt;
            r_wait_cnt <= w_wait_nxt;
            if ((w_mem_stall | w_lu_hazard) && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
        end
    end

    // Next-state logic and output decode; every output is forced low in reset.
    always_comb begin
        w_state_nxt    = r_state;
        w_we_nxt       = r_we;
        w_wait_nxt     = r_wait_cnt;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        PC_stall_o     = 1'b0;
        IFID_stall_o   = 1'b0;
        IDEX_stall_o   = 1'b0;
        IDEX_bubble_o  = 1'b0;
        EXMEM_stall_o  = 1'b0;
        MEMWB_bubble_o = 1'b0;
        busy_o         = 1'b0;
        timeout_o      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_memop) begin
                    w_state_nxt = ST_ACCESS;
                    w_we_nxt    = EXMEM_MemWrite_i;
                    w_wait_nxt  = '0;
                end
            end
            ST_ACCESS: begin
                if (mem_ack_i) begin
                    w_state_nxt = ST_DONE;
                end else if ((TIMEOUT != 0) && (r_wait_cnt == c_WAIT_LAST)) begin
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_wait_nxt = r_wait_cnt + c_WAIT_ONE;
                end
            end
            // Always return to IDLE so the completed access is not reissued.
            ST_DONE:  w_state_nxt = ST_IDLE;
            ST_ERROR: w_state_nxt = ST_ERROR;
            default:  w_state_nxt = ST_IDLE;
        endcase

        if (rst_i) begin
            mem_req_o = (r_state == ST_ACCESS);
            mem_we_o  = (r_state == ST_ACCESS) & r_we;
            busy_o    = (r_state != ST_IDLE);
            timeout_o = (r_state == ST_ERROR);
            if (w_mem_stall) begin
                PC_stall_o     = 1'b1;
                IFID_stall_o   = 1'b1;
                IDEX_stall_o   = 1'b1;
                EXMEM_stall_o  = 1'b1;
                MEMWB_bubble_o = 1'b1;
            end else if (w_lu_hazard) begin
                PC_stall_o    = 1'b1;
                IFID_stall_o  = 1'b1;
                IDEX_bubble_o = 1'b1;
            end
        end
    end

    assign stall_cnt_o = rst_i ? r_stall_cnt : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stall_ctrl
//  Brief    : Self-checking bench for mem_stall_ctrl. A cycle model pushes the
//             expected outputs when inputs are driven; they are popped and
//             compared when the DUT outputs are sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stall_ctrl;

    localparam int c_TO = 4;
    localparam int c_CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_rd, ex_wr, id_rd, ack;
    logic [4:0]      id_rd_addr, rs1, rs2;
    logic            mem_req, mem_we, pc_stall, ifid_stall, idex_stall, idex_bub;
    logic            exmem_stall, memwb_bub, busy, tmo;
    logic [c_CW-1:0] cnt;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int n_req   = 0;
    int n_exs   = 0;

    logic [13:0] exp_q[$];

    // Reference model state
    int   m_state = 0;   // 0 idle, 1 access, 2 done, 3 error
    logic m_we    = 1'b0;
    int   m_seen  = 0;   // access cycles elapsed without ack
    int   m_cnt   = 0;

    always #5 clk = ~clk;

    mem_stall_ctrl #(.TIMEOUT(c_TO), .CNT_W(c_CW)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .EXMEM_MemRead_i (ex_rd),
        .EXMEM_MemWrite_i(ex_wr),
        .IDEX_MemRead_i  (id_rd),
        .IDEX_RDaddr_i   (id_rd_addr),
        .IFID_RS1addr_i  (rs1),
        .IFID_RS2addr_i  (rs2),
        .mem_ack_i       (ack),
        .mem_req_o       (mem_req),
        .mem_we_o        (mem_we),
        .PC_stall_o      (pc_stall),
        .IFID_stall_o    (ifid_stall),
        .IDEX_stall_o    (idex_stall),
        .IDEX_bubble_o   (idex_bub),
        .EXMEM_stall_o   (exmem_stall),
        .MEMWB_bubble_o  (memwb_bub),
        .busy_o          (busy),
        .timeout_o       (tmo),
        .stall_cnt_o     (cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [13:0] model_out();
        logic memop, ms, lu;
        if (!rst) return 14'd0;
        memop = ex_rd | ex_wr;
        ms = (m_state == 0 && memop) || m_state == 1 || m_state == 3;
        lu = id_rd && (id_rd_addr != 5'd0) && (id_rd_addr == rs1 || id_rd_addr == rs2);
        return {m_state == 1, m_state == 1 && m_we, ms || lu, ms || lu, ms,
                !ms && lu, ms, ms, m_state != 0, m_state == 3, 4'(m_cnt)};
    endfunction

    task automatic model_next();
        logic memop, ms, lu;
        if (!rst) begin
            m_state = 0; m_we = 1'b0; m_seen = 0; m_cnt = 0;
        end else begin
            memop = ex_rd | ex_wr;
            ms = (m_state == 0 && memop) || m_state == 1 || m_state == 3;
            lu = id_rd && (id_rd_addr != 5'd0) && (id_rd_addr == rs1 || id_rd_addr == rs2);
            if ((ms || lu) && m_cnt < 15) m_cnt++;
            case (m_state)
                0: if (memop) begin m_state = 1; m_we = ex_wr; m_seen = 0; end
                1: begin
                    m_seen++;
                    if (ack) m_state = 2;
                    else if (m_seen == c_TO) m_state = 3;
                end
                2: m_state = 0;
                default: ;
            endcase
        end
    endtask

    // One clock cycle with the currently driven inputs.
    task automatic step();
        logic [13:0] e;
        exp_q.push_back(model_out());
        @(negedge clk);
        e = exp_q.pop_front();
        check_val("ctl", {mem_req, mem_we, pc_stall, ifid_stall, idex_stall, idex_bub,
                          exmem_stall, memwb_bub, busy, tmo}, e[13:4]);
        check_val("cnt", cnt, e[3:0]);
        if (mem_req) n_req++;
        if (exmem_stall) n_exs++;
        model_next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic ak);
        ex_rd = rd; ex_wr = wr; ack = ak;
        step();
    endtask

    task automatic hazard(input logic ld, input logic [4:0] rd_a, input logic [4:0] a1, input logic [4:0] a2);
        id_rd = ld; id_rd_addr = rd_a; rs1 = a1; rs2 = a2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        hazard(1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        n_req = 0;
        n_exs = 0;
    endtask

    initial begin
        rst = 1'b0;
        ex_rd = 1'b0; ex_wr = 1'b0; ack = 1'b0;
        hazard(1'b0, 5'd0, 5'd0, 5'd0);
        step();
        do_reset();

        // Load, ack in the 3rd access cycle
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        check_val("t1_req_cycles", n_req, 3);
        check_val("t1_exmem_cycles", n_exs, 4);
        check_val("t1_cnt", cnt, 4);
        drive(1'b0, 1'b0, 1'b0);

        // Store with immediate ack, then a load
        do_reset();
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        check_val("t2_cnt", cnt, 4);
        check_val("t2_req_cycles", n_req, 2);
        drive(1'b0, 1'b0, 1'b0);

        // Load-use hazard on rs2, rs1, then with rd = x0
        do_reset();
        hazard(1'b1, 5'd5, 5'd0, 5'd5);
        drive(1'b0, 1'b0, 1'b0);
        check_val("t3_bubble_cnt", cnt, 1);
        drive(1'b0, 1'b0, 1'b0);
        hazard(1'b1, 5'd7, 5'd7, 5'd1);
        drive(1'b0, 1'b0, 1'b0);
        hazard(1'b1, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 1'b0);
        hazard(1'b0, 5'd5, 5'd5, 5'd5);
        drive(1'b0, 1'b0, 1'b0);
        check_val("t3_cnt", cnt, 3);

        // Hazard coincident with a memory access, still present after DONE
        do_reset();
        hazard(1'b1, 5'd9, 5'd9, 5'd2);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        hazard(1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 1'b0, 1'b0);
        check_val("t4_cnt", cnt, 5);

        // Timeout: no ack for 4 access cycles, late acks ignored, reset clears
        do_reset();
        drive(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < c_TO; i++) drive(1'b0, 1'b1, 1'b0);
        check_val("t5_timeout", tmo, 1);
        check_val("t5_req_off", mem_req, 0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1);
        check_val("t5_still_err", tmo, 1);
        do_reset();
        drive(1'b0, 1'b0, 1'b0);
        check_val("t5_cleared", tmo, 0);

        // Reset in the 2nd access cycle, late ack afterwards
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check_val("t6_busy", busy, 0);
        check_val("t6_cnt", cnt, 0);

        // Saturation of the stall counter
        do_reset();
        hazard(1'b1, 5'd3, 5'd3, 5'd3);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0);
        check_val("t7_sat", cnt, 15);

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            hazard(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) == 0));
        end

        check_val("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
